sp_rx_aligner: RTL and testbench
================================

SP_RX_ALIGNER -- requirements
Module: sp_rx_aligner

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC: the K28.5 comma/idle symbol.
REQ-002 SHALL have parameter ALIGN_N, default 4: the number of consecutive aligned commas needed to declare the link active.
REQ-003 SHALL have port clk_32f, input, 1 bit: the sole clock (bit rate); all logic samples on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 1 bit: the serial bit stream from the TX parallel-to-serial stage, MSB first.
REQ-006 SHALL have port data_out, output, 8 bits: the recovered byte.
REQ-007 SHALL have port valid_out, output, 1 bit: data_out holds a non-comma data byte.
REQ-008 SHALL have port active, output, 1 bit: byte alignment is locked.

Function
REQ-009 SHALL shift on every edge, shift_reg <= {shift_reg[6:0], data_in}; nxt denotes {shift_reg[6:0], data_in}.
REQ-010 SHALL implement three states, SEARCH, COUNT and ACTIVE, with SEARCH as the reset state.
REQ-011 In SEARCH, SHALL compare nxt against COMMA on every edge (bit-sliding); on a match it goes to COUNT with bit_cnt=0 and comma_cnt=1.
REQ-012 In COUNT and ACTIVE, bit_cnt (3 bits) SHALL increment every edge and wrap from 7 to 0; a byte boundary is an edge where bit_cnt==7.
REQ-013 In COUNT at a boundary, if nxt==COMMA, comma_cnt SHALL increment, and when the incremented value equals ALIGN_N the block goes to ACTIVE.
REQ-014 In COUNT at a boundary, if nxt!=COMMA, the block SHALL return to SEARCH with comma_cnt=0; sliding search resumes on the next edge.
REQ-015 In COUNT, no byte SHALL be output, and active and valid_out SHALL remain 0.
REQ-016 active SHALL be registered: it rises on the edge that enters ACTIVE and stays 1 until reset.
REQ-017 In ACTIVE at a boundary: if nxt!=COMMA, data_out<=nxt and valid_out<=1; if nxt==COMMA, valid_out<=0 and data_out holds its previous value.
REQ-018 Between boundaries, data_out and valid_out SHALL hold, so each byte stays stable for 8 clk_32f cycles (one clk_4f period).
REQ-019 Latency SHALL be 1 edge: a byte whose last bit is sampled at edge k is visible on data_out after edge k.
REQ-020 The first boundary after entering ACTIVE SHALL be exactly 8 edges after the ALIGN_N-th comma boundary.
REQ-021 comma_cnt SHALL be ceil(log2(ALIGN_N+1)) bits wide; an ALIGN_N of 1 makes the block go to ACTIVE on the first boundary comma.
REQ-022 In ACTIVE, misaligned comma patterns SHALL be ignored, with no realignment and no loss-of-lock.

Reset
REQ-023 While reset=0, the block SHALL asynchronously clear state to SEARCH, with shift_reg=0, bit_cnt=0, comma_cnt=0, data_out=8'h00, valid_out=0 and active=0.
REQ-024 A reset asserted mid-byte or mid-ACTIVE SHALL discard the partial byte; after release, the block requires a fresh sliding search plus ALIGN_N commas.

Configuration
REQ-025 With macro SP_RX_ERRCNT_EN defined, the block SHALL add output err_cnt, 8 bits, reset to 0.
REQ-026 With SP_RX_ERRCNT_EN defined, err_cnt SHALL increment once per COUNT-to-SEARCH fallback and saturate at 8'hFF.
REQ-027 Without SP_RX_ERRCNT_EN, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package pcie_phy_pkg SHALL hold the COMMA constant (8'hBC), the state encoding (SEARCH=2'd0, COUNT=2'd1, ACTIVE=2'd2) and the byte-width constant 8.
REQ-029 The block SHALL be a single module with no sub-module; the comparator and the shifter are inline.

Verification
REQ-030 Reset low for 3 edges mid-stream -> all outputs 0 asynchronously; after release, state is SEARCH.
REQ-031 Bits 3'b101, then 4x BC, then A5 -> active rises on the 4th comma boundary; data_out=8'hA5 with valid_out=1 one edge after A5's last bit, held 8 edges.
REQ-032 3x BC, then 8'h3C, then 4x BC, then FF -> no active after the first run; active rises only after the second run; data_out=8'hFF.
REQ-033 Locked link, stream BC FF EE BC 12 -> valid_out sequence 0,1,1,0,1; data_out FF,EE,EE(hold),12.
REQ-034 Locked link, reset pulse mid-byte, then 4x BC, then 5A -> active drops immediately, relocks, data_out=8'h5A.
REQ-035 With SP_RX_ERRCNT_EN, 300 broken comma runs -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared PHY constants and the receive aligner state encoding.
package pcie_phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;
endpackage

// File: rtl/sp_rx_aligner.sv
// sp_rx_aligner: serial bit stream to byte aligner locking on ALIGN_N boundary commas.
// Define SP_RX_ERRCNT_EN to add a saturating err_cnt of COUNT-to-SEARCH fallbacks.
module sp_rx_aligner import pcie_phy_pkg::*; #(
  parameter logic [BYTE_W-1:0] COMMA = pcie_phy_pkg::COMMA,
  parameter int ALIGN_N = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
`ifdef SP_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  localparam int CW = $clog2(ALIGN_N + 1);
  state_t state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d, data_q, data_d, nxt;
  logic [2:0] bit_q, bit_d;
  logic [CW-1:0] comma_q, comma_d;
  logic [CW:0] comma_inc;
  logic valid_q, valid_d, active_q, active_d, hit, bnd;
  assign nxt = {shift_q[BYTE_W-2:0], data_in};
  assign hit = nxt == COMMA;
  assign bnd = bit_q == 3'd7;
  // One extra bit so ALIGN_N == 1 still compares correctly after the increment.
  assign comma_inc = {1'b0, comma_q} + 1'b1;
  always_comb begin
    shift_d = nxt;
    state_d = state_q;
    bit_d = bit_q + 3'd1;
    comma_d = comma_q;
    data_d = data_q;
    valid_d = valid_q;
    active_d = active_q;
    case (state_q)
      SEARCH: begin
        bit_d = '0;
        if (hit) begin
          state_d = COUNT;
          comma_d = CW'(1);
        end
      end
      COUNT: if (bnd) begin
        if (!hit) begin
          state_d = SEARCH;
          comma_d = '0;
        end else begin
          comma_d = comma_inc[CW-1:0];
          if (comma_inc >= (CW+1)'(ALIGN_N)) begin
            state_d = ACTIVE;
            active_d = 1'b1;
          end
        end
      end
      ACTIVE: if (bnd) begin
        valid_d = !hit;
        data_d = hit ? data_q : nxt;
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      shift_q <= '0;
      bit_q <= '0;
      comma_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      comma_q <= comma_d;
      data_q <= data_d;
      valid_q <= valid_d;
      active_q <= active_d;
    end
  end
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign active = active_q;
`ifdef SP_RX_ERRCNT_EN
  logic [7:0] err_q, err_d;
  logic fall;
  assign fall = state_q == COUNT && bnd && !hit;
  assign err_d = (fall && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_cnt = err_q;
`endif
endmodule

// File: tb/tb_sp_rx_aligner.sv
// tb_sp_rx_aligner: directed serial streams with hand-computed lock and byte outputs.
module tb_sp_rx_aligner;
  logic clk_32f = 1'b0, reset = 1'b0, data_in = 1'b0;
  logic [7:0] data_out;
  logic valid_out, active;
  logic [9:0] st;
  int checks = 0, errors = 0;
`ifdef SP_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  sp_rx_aligner dut (
    .clk_32f(clk_32f),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .active(active)
`ifdef SP_RX_ERRCNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  always #5 clk_32f = ~clk_32f;
  assign st = {active, valid_out, data_out};

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b0;
    #1 chk("rst_async", st, 10'h000);
    repeat (3) @(posedge clk_32f);
    #1 chk("rst_hold", st, 10'h000);
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk_32f);
    #1 chk("reset", st, 10'h000);
    @(negedge clk_32f);
    reset = 1'b1;
    repeat (3) send_bit(1'b0);
    // Broken first run must not lock; the second clean run does.
    repeat (3) send_byte(8'hBC);
    chk("run1_3bc", st, 10'h000);
    send_byte(8'h3C);
    chk("run1_broken", st, 10'h000);
    repeat (3) send_byte(8'hBC);
    chk("run2_3bc", st, 10'h000);
    send_byte(8'hBC);
    chk("run2_lock", st, {2'b10, 8'h00});
    send_byte(8'hFF);
    chk("run2_ff", st, {2'b11, 8'hFF});
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    chk("slide_3bc", st, 10'h000);
    send_byte(8'hBC);
    chk("slide_lock", st, {2'b10, 8'h00});
    b = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    chk("a5_pre", st, {2'b10, 8'h00});
    send_bit(b[0]);
    chk("a5", st, {2'b11, 8'hA5});
    b = 8'hBC;
    for (int i = 7; i >= 1; i--) begin
      send_bit(b[i]);
      chk("a5_hold", st, {2'b11, 8'hA5});
    end
    send_bit(b[0]);
    chk("idle_bc", st, {2'b10, 8'hA5});
    send_byte(8'hFF);
    chk("seq_ff", st, {2'b11, 8'hFF});
    send_byte(8'hEE);
    chk("seq_ee", st, {2'b11, 8'hEE});
    send_byte(8'hBC);
    chk("seq_bc_hold", st, {2'b10, 8'hEE});
    send_byte(8'h12);
    chk("seq_12", st, {2'b11, 8'h12});
    // 0B C0 hides a comma at a bit offset; a locked link ignores it.
    send_byte(8'h0B);
    chk("mis_0b", st, {2'b11, 8'h0B});
    send_byte(8'hC0);
    chk("mis_c0", st, {2'b11, 8'hC0});
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    pulse_reset();
    repeat (3) send_byte(8'hBC);
    chk("relock_3bc", st, 10'h000);
    send_byte(8'hBC);
    chk("relock", st, {2'b10, 8'h00});
    send_byte(8'h5A);
    chk("relock_5a", st, {2'b11, 8'h5A});
`ifdef SP_RX_ERRCNT_EN
    pulse_reset();
    chk("err_reset", {2'b00, err_cnt}, 10'h000);
    send_byte(8'hBC);
    send_byte(8'h00);
    chk("err_one", {2'b00, err_cnt}, 10'h001);
    repeat (299) begin
      send_byte(8'hBC);
      send_byte(8'h00);
    end
    chk("err_sat", {2'b00, err_cnt}, 10'h0FF);
    chk("err_noact", st, 10'h000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
